// File: rtl/md_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Holds the op codes and the control FSM state type.
package md_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE    = 2'b00,
    MD_MUL     = 2'b01,
    MD_DIV_RUN = 2'b10,
    MD_FINISH  = 2'b11
  } md_state_e;

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate used for sign correction.
// Ports: i_val value, i_neg negate enable, o_val corrected value.
module md_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (-i_val) : i_val;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with 64-bit HI/LO result.
// Ports: clk, reset, start, op, operandA/B in; busy, done, divByZero, hi, lo out.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic             busy,
  output logic             done,
  output logic             divByZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  md_state_e          r_state;
  md_state_e          w_next;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_m;
  logic [WIDTH-1:0]   r_a_orig;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_done;
  logic               r_dz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_accept;
  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;

  assign w_accept = (r_state == MD_IDLE) && start;
  assign w_signed = ~op[0];
  assign w_a_neg  = w_signed & operandA[WIDTH-1];
  assign w_b_neg  = w_signed & operandB[WIDTH-1];
  assign w_a_mag  = w_a_neg ? (-operandA) : operandA;
  assign w_b_mag  = w_b_neg ? (-operandB) : operandB;

  // Shift-add: low half holds the multiplier, consumed LSB first.
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_nxt;

  assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
               + (r_acc[0] ? {1'b0, r_m} : '0);
  assign w_mul_nxt = {w_sum, r_acc[WIDTH-1:1]};

  // Restoring divide: {remainder, quotient} shifted left each step.
  logic [WIDTH:0]     w_dhi;
  logic [WIDTH+1:0]   w_diff;
  logic               w_borrow;
  logic [2*WIDTH-1:0] w_div_nxt;

  assign w_dhi    = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff   = {1'b0, w_dhi} - {2'b00, r_m};
  assign w_borrow = w_diff[WIDTH+1];
  assign w_div_nxt = {
    (w_borrow ? w_dhi[WIDTH-1:0] : w_diff[WIDTH-1:0]),
    r_acc[WIDTH-2:0],
    ~w_borrow
  };

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic               w_dz;

  assign w_dz = (r_m == '0);

  md_sign_fix #(.W(2*WIDTH)) u_fix_prod (
    .i_val (r_acc),
    .i_neg (r_neg_q),
    .o_val (w_prod)
  );

  md_sign_fix #(.W(WIDTH)) u_fix_quo (
    .i_val (r_acc[WIDTH-1:0]),
    .i_neg (r_neg_q),
    .o_val (w_quo)
  );

  md_sign_fix #(.W(WIDTH)) u_fix_rem (
    .i_val (r_acc[2*WIDTH-1:WIDTH]),
    .i_neg (r_neg_r),
    .o_val (w_rem)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= MD_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      MD_IDLE: begin
        if (start) w_next = op[1] ? MD_DIV_RUN : MD_MUL;
      end
      MD_MUL, MD_DIV_RUN: begin
        if (r_cnt == LAST) w_next = MD_FINISH;
      end
      MD_FINISH: w_next = MD_IDLE;
      default:   w_next = MD_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != MD_IDLE);
    done      = r_done;
    divByZero = r_dz;
    hi        = r_hi;
    lo        = r_lo;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_m      <= '0;
      r_a_orig <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        MD_IDLE: begin
          if (w_accept) begin
            r_cnt    <= '0;
            r_is_div <= op[1];
            r_a_orig <= operandA;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_dz     <= 1'b0;
            r_m      <= op[1] ? w_b_mag : w_a_mag;
            r_acc    <= {{WIDTH{1'b0}},
                         (op[1] ? w_a_mag : w_b_mag)};
          end
        end
        MD_MUL: begin
          if (r_cnt != LAST) begin
            r_acc <= w_mul_nxt;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        MD_DIV_RUN: begin
          if (r_cnt != LAST) begin
            r_acc <= w_div_nxt;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        MD_FINISH: begin
          r_done <= 1'b1;
          if (r_is_div) begin
            if (w_dz) begin
              r_hi <= r_a_orig;
              r_lo <= '1;
              r_dz <= 1'b1;
            end else begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end
          end else begin
            {r_hi, r_lo} <= w_prod;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
// Table of op vectors plus hand sequences for re-start and reset.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic        busy;
  logic        done;
  logic        divByZero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .operandA  (operandA),
    .operandB  (operandB),
    .busy      (busy),
    .done      (done),
    .divByZero (divByZero),
    .hi        (hi),
    .lo        (lo)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Accept edge is "edge 0"; returns one time unit after it.
  task automatic issue(input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    op = o; operandA = a; operandB = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = ~o;
    operandA = $urandom;
    operandB = $urandom;
  endtask

  // Counts edges until done is seen; bounded at 100 edges.
  task automatic wait_done(output int lat, output logic busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int          lat;
    logic        bok;
    logic [31:0] keep_hi;
    logic [31:0] keep_lo;

    vecs[0]  = '{2'b00, 32'hFFFFFFF9, 32'd6,
                 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2]  = '{2'b10, 32'hFFFFFFEF, 32'd5,
                 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{2'b11, 32'd100, 32'd7,
                 32'd2, 32'd14, 1'b0};
    vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF,
                 32'h0, 32'h80000000, 1'b0};
    vecs[5]  = '{2'b11, 32'd42, 32'd0,
                 32'd42, 32'hFFFFFFFF, 1'b1};
    vecs[6]  = '{2'b00, 32'd3, 32'd4,
                 32'd0, 32'd12, 1'b0};
    vecs[7]  = '{2'b10, 32'd17, 32'hFFFFFFFB,
                 32'd2, 32'hFFFFFFFD, 1'b0};
    vecs[8]  = '{2'b00, 32'h80000000, 32'd2,
                 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[9]  = '{2'b10, 32'hFFFFFFEC, 32'd0,
                 32'hFFFFFFEC, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{2'b01, 32'h12345678, 32'h10,
                 32'h00000001, 32'h23456780, 1'b0};
    vecs[11] = '{2'b11, 32'hFFFFFFFF, 32'd1,
                 32'h0, 32'hFFFFFFFF, 1'b0};

    reset = 1'b1; start = 1'b0; op = 2'b00;
    operandA = '0; operandB = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_dz", {63'b0, divByZero}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d_busy0", i), {63'b0, busy}, 64'd1);
      chk($sformatf("v%0d_dzclr", i), {63'b0, divByZero}, 64'd0);
      wait_done(lat, bok);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'd34);
      chk($sformatf("v%0d_busyrun", i), {63'b0, bok}, 64'd1);
      chk($sformatf("v%0d_busyfall", i), {63'b0, busy}, 64'd0);
      chk($sformatf("v%0d_hi", i), {32'b0, hi}, {32'b0, vecs[i].hi});
      chk($sformatf("v%0d_lo", i), {32'b0, lo}, {32'b0, vecs[i].lo});
      chk($sformatf("v%0d_dz", i), {63'b0, divByZero},
          {63'b0, vecs[i].dz});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_donepulse", i), {63'b0, done}, 64'd0);
      chk($sformatf("v%0d_hold", i), {hi, lo},
          {vecs[i].hi, vecs[i].lo});
    end

    // Start re-pulsed mid-operation must be ignored.
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (9) @(posedge clk);
    #1;
    op = 2'b00; operandA = 32'd3; operandB = 32'd4; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, bok);
    chk("ign_lat", 64'(lat), 64'd24);
    chk("ign_busy", {63'b0, bok}, 64'd1);
    chk("ign_res", {hi, lo}, 64'hFFFFFFFE_00000001);
    keep_hi = hi;
    keep_lo = lo;

    // New start accepted during the done cycle.
    op = 2'b00; operandA = 32'hFFFFFFFE; operandB = 32'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_busy", {63'b0, busy}, 64'd1);
    chk("b2b_done0", {63'b0, done}, 64'd0);
    chk("b2b_stable", {hi, lo}, {keep_hi, keep_lo});
    wait_done(lat, bok);
    chk("b2b_lat", 64'(lat), 64'd34);
    chk("b2b_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFF6);

    // Reset mid-divide clears everything at once.
    issue(2'b10, 32'd1000, 32'd3);
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("mrst_busy", {63'b0, busy}, 64'd0);
    chk("mrst_done", {63'b0, done}, 64'd0);
    chk("mrst_dz", {63'b0, divByZero}, 64'd0);
    chk("mrst_hilo", {hi, lo}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    issue(2'b00, 32'd3, 32'd4);
    wait_done(lat, bok);
    chk("post_lat", 64'(lat), 64'd34);
    chk("post_res", {hi, lo}, 64'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit that consumes the two operands read from the register file (readData1 → operandA, readData2 → operandB) and produces a 64-bit result in HI/LO registers for MULT, MULTU, DIV and DIVU. It sits in the execute stage beside the ALU. Control starts an operation with a one-cycle `start` pulse and holds off dependent instructions while `busy` is high. Results remain readable until the next operation completes.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  one-cycle request; sampled only in IDLE.
- op  input  2  operation: MULT=2'b00, MULTU=2'b01, DIV=2'b10, DIVU=2'b11.
- operandA  input  WIDTH  multiplicand / dividend (from readData1).
- operandB  input  WIDTH  multiplier / divisor (from readData2).
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when hi/lo take the new result.
- divByZero  output  1  set with done when a DIV/DIVU had operandB==0; cleared on the next accepted start.
- hi  output  WIDTH  upper product word / remainder.
- lo  output  WIDTH  lower product word / quotient.

## Operation
- States: IDLE, MUL, DIV, FINISH.
- IDLE + start:
  - latch op and operand magnitudes; signed ops take the absolute value, and the result sign is recorded.
  - counter=0, busy=1, divByZero=0.
  - Next state is MUL (op[1]=0) or DIV (op[1]=1).
- IDLE without start: no state change.
- MUL: one shift-add step per cycle on a 2·WIDTH accumulator; after WIDTH steps → FINISH.
- DIV: one restoring shift-subtract step per cycle on a 2·WIDTH remainder/quotient register; after WIDTH steps → FINISH.
- FINISH:
  - Apply sign correction:
    - product negated if the operand signs differ (MULT);
    - quotient negated if the signs differ, remainder takes the dividend's sign (DIV).
  - Write hi/lo, pulse done, busy=0 → IDLE.
- Divide by zero: runs full latency; result hi=operandA (original value), lo={WIDTH{1'b1}}, divByZero=1.
- DIV of -2^(WIDTH-1) by -1: lo=0x80000000, hi=0 (no trap).
- Unsigned ops perform no sign handling; MULTU 0xFFFFFFFF·0xFFFFFFFF = hi 0xFFFFFFFE, lo 0x00000001.
- start while busy: ignored; the operation in flight is unaffected.
- Operand/op changes after the accepting cycle have no effect.
- Reset (any time, including mid-operation): state=IDLE, busy=0, done=0, divByZero=0, hi=0, lo=0, counter=0.

## Timing
- Cycle 0: start sampled high in IDLE.
- Cycles 1..WIDTH: iteration (busy=1).
- Cycle WIDTH+1: FINISH.
- hi/lo/done/divByZero update at the rising edge ending FINISH, i.e. visible WIDTH+2 edges after the start edge (34 for WIDTH=32).
- busy falls together with the done rise.
- A new start may be accepted in the cycle done is high; back-to-back issue interval is WIDTH+2 cycles.
- hi/lo are stable between done pulses; no combinational path from the inputs to the outputs.

## Structure
- Shared package `md_pkg`:
  - op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU;
  - state enum MD_IDLE, MD_MUL, MD_DIV, MD_FINISH.
- Counter width: $clog2(WIDTH)+1.
- One sub-module is natural: `md_sign_fix`, a combinational conditional two's-complement negate of the quotient/remainder/product. Everything else stays in `mult_div_unit`.

## Test plan
- MULT: operandA=-7 (0xFFFFFFF9), operandB=6 → after 34 cycles hi=0xFFFFFFFF, lo=0xFFFFFFD6; done for exactly 1 cycle; busy high for cycles 1..33.
- MULTU: 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV:
  - -17 / 5 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFE (-2).
  - DIVU 100/7 → lo=14, hi=2.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. DIVU 42/0 → lo=0xFFFFFFFF, hi=42, divByZero=1.
- start re-pulsed at cycle 10 of a MULTU with different operands → ignored, original result delivered at cycle 34. Then a new start during the done cycle → accepted.
- Reset asserted at cycle 15 of a DIV → outputs immediately 0 and busy=0. After release, a MULT 3×4 completes with lo=12, hi=0.
